// File: rtl/irrigation_timer_controller.sv
// Purpose: one irrigation cycle. Loads a BCD MM:S0 preset, opens the valve and counts down once per tick.
// Latency: every output is registered and changes on the edge after the input or tick that causes it.
// Backpressure: none. Level inputs are sampled every cycle, and start_pulse is a one-cycle strobe.
//
// Optional feature macro: TIMER_PAUSE_EN. When it is defined, a drop of irrigation_enable during RUN
// enters a PAUSE state that freezes the count and the prescaler. Without it, the drop aborts to IDLE.
// Ports: clock, reset_n (async, active-low); start_pulse, stop_n, irrigation_enable and
//        conflicting_values are the control inputs; preset_minutes_d/_u and preset_seconds_d give the
//        preset; valve_on drives the valve; minutes_d/_u and seconds_d/_u hold the remaining time;
//        done pulses on natural expiry; fault is high while the block is in FAULT.
module irrigation_timer_controller #(
    parameter int TICK_CYCLES = 50000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start_pulse,
    input  logic       stop_n,
    input  logic       irrigation_enable,
    input  logic       conflicting_values,
    input  logic [1:0] preset_minutes_d,
    input  logic [3:0] preset_minutes_u,
    input  logic [2:0] preset_seconds_d,
    output logic       valve_on,
    output logic [1:0] minutes_d,
    output logic [3:0] minutes_u,
    output logic [2:0] seconds_d,
    output logic [3:0] seconds_u,
    output logic       done,
    output logic       fault
);
    localparam int PW = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

    typedef struct packed {
        logic [1:0] md;
        logic [3:0] mu;
        logic [2:0] sd;
        logic [3:0] su;
    } count_t;

`ifdef TIMER_PAUSE_EN
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DONE, S_FAULT, S_PAUSE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAULT} state_t;
`endif

    state_t        state_q, state_d;
    count_t        count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          valve_q, valve_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;

    logic preset_bad, preset_zero, start_ok, tick, at_one, reload;

    // Cascaded BCD borrow: each digit wraps to its maximum and borrows from the next one up.
    function automatic count_t bcd_dec(input count_t c);
        count_t r;
        r = c;
        if (c.su != 4'd0) begin
            r.su = c.su - 4'd1;
        end else begin
            r.su = 4'd9;
            if (c.sd != 3'd0) begin
                r.sd = c.sd - 3'd1;
            end else begin
                r.sd = 3'd5;
                if (c.mu != 4'd0) begin
                    r.mu = c.mu - 4'd1;
                end else begin
                    r.mu = 4'd9;
                    r.md = c.md - 2'd1;
                end
            end
        end
        return r;
    endfunction

    assign preset_bad  = (preset_minutes_u > 4'd9) || (preset_seconds_d > 3'd5);
    assign preset_zero = (preset_minutes_d == 2'd0) && (preset_minutes_u == 4'd0) &&
                         (preset_seconds_d == 3'd0);
    assign start_ok    = start_pulse && !preset_bad && !preset_zero;
    assign tick        = (presc_q == TICK_LAST);
    assign at_one      = (count_q == 13'd1);

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            presc_q <= '0;
            valve_q <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            valve_q <= valve_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    // Next state. Each branch chain follows the order conflict > stop > enable > start > tick.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (conflicting_values)                  state_d = S_FAULT;
                else if (!stop_n || !irrigation_enable)  state_d = S_IDLE;
                else if (start_pulse && preset_bad)      state_d = S_FAULT;
                else if (start_ok)                       state_d = S_RUN;
            end
            S_RUN: begin
                if (conflicting_values) begin
                    state_d = S_FAULT;
                end else if (!stop_n) begin
                    state_d = S_IDLE;
                end else if (!irrigation_enable) begin
`ifdef TIMER_PAUSE_EN
                    state_d = S_PAUSE;
`else
                    state_d = S_IDLE;
`endif
                end else if (start_pulse && preset_bad) begin
                    state_d = S_FAULT;
                end else if (start_ok) begin
                    state_d = S_RUN;
                end else if (tick && at_one) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = conflicting_values ? S_FAULT : S_IDLE;
            end
            S_FAULT: begin
                // Leave FAULT only on an operator acknowledge: the conflict is clear and stop is pressed.
                if (!conflicting_values && !stop_n) state_d = S_IDLE;
            end
`ifdef TIMER_PAUSE_EN
            S_PAUSE: begin
                if (conflicting_values)      state_d = S_FAULT;
                else if (!stop_n)            state_d = S_IDLE;
                else if (irrigation_enable)  state_d = S_RUN;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output values, all taken from the transition being made.
    always_comb begin
        count_d = count_q;
        presc_d = presc_q;
        valve_d = (state_d == S_RUN);
        done_d  = (state_d == S_DONE);
        fault_d = (state_d == S_FAULT);
        reload  = start_ok && (state_d == S_RUN) &&
                  ((state_q == S_IDLE) || (state_q == S_RUN));

        if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
            count_d = '0;
            presc_d = '0;
        end else if (reload) begin
            count_d = {preset_minutes_d, preset_minutes_u, preset_seconds_d, 4'd0};
            presc_d = '0;
        end else if ((state_q == S_RUN) && ((state_d == S_RUN) || (state_d == S_DONE))) begin
            // Only an undisturbed RUN cycle advances time. A pre-empted tick is dropped.
            if (tick) begin
                count_d = bcd_dec(count_q);
                presc_d = '0;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    assign valve_on  = valve_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign minutes_d = count_q.md;
    assign minutes_u = count_q.mu;
    assign seconds_d = count_q.sd;
    assign seconds_u = count_q.su;

endmodule
